qar_spi_target: RTL and testbench



---
 rtl/qar_spi_target.sv | 206 ++++++++++++++++++++
 tb/tb_qar_spi_target.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_spi_target.sv
// QAR SPI target: oversamples an external controller's SCK/CS_N/MOSI on clk and
// moves bytes through TX/RX FIFOs behind the standard QAR register bus and IRQ.
module qar_spi_target #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [5:0]  addr_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    localparam logic [5:0] A_CTRL       = 6'd0;
    localparam logic [5:0] A_STATUS     = 6'd1;
    localparam logic [5:0] A_TXDATA     = 6'd3;
    localparam logic [5:0] A_RXDATA     = 6'd4;
    localparam logic [5:0] A_IRQ_EN     = 6'd6;
    localparam logic [5:0] A_IRQ_STATUS = 6'd7;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic        start, stop;

    logic        sck_s1, sck_s2, sck_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  sync_age;

    logic        enable, cpol, cpha, lsb_first;
    logic [3:0]  irq_en, irq_status;
    logic        fault;

    logic [2:0]  bit_cnt;
    logic [7:0]  tx_shift, rx_shift;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [AW:0] tx_count, rx_count, tx_count_next, rx_count_next;
    logic        tx_empty, tx_full, rx_empty, rx_full;

    logic        sync_ok, cs_fall, cs_rise, sck_edge, lead_edge, trail_edge;
    logic        shift_edge, sample_edge, load;
    logic        tx_push_req, tx_push, tx_pop, tx_drop, underrun;
    logic        rx_push_req, rx_push, rx_pop, overrun;
    logic        wr_ctrl, wr_irq_en;
    logic [3:0]  w1c, irq_set, irq_clr;
    logic [7:0]  rx_byte_new;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    // The synchronizer resets to "CS high", so a pin already low at reset release
    // would look like a falling edge; edges count only once the pipe holds real samples.
    assign sync_ok    = (sync_age == 2'd3);
    assign cs_fall    = sync_ok && cs_d && !cs_s2;
    assign cs_rise    = sync_ok && !cs_d && cs_s2;
    assign sck_edge   = sync_ok && (sck_s2 != sck_d);
    assign lead_edge  = sck_edge && (sck_s2 != cpol);
    assign trail_edge = sck_edge && (sck_s2 == cpol);

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: if (cs_fall && enable) begin
                state_d = ACTIVE;
                start   = 1'b1;
            end
            ACTIVE: if (cs_rise || !enable) begin
                state_d = IDLE;
                stop    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_edge  = (state_q == ACTIVE) && !stop && (cpha ? lead_edge : trail_edge);
    assign sample_edge = (state_q == ACTIVE) && !stop && (cpha ? trail_edge : lead_edge);
    assign load        = (start && !cpha) || (shift_edge && (bit_cnt == 3'd0));
    assign rx_byte_new = lsb_first ? {mosi_s2, rx_shift[7:1]} : {rx_shift[6:0], mosi_s2};

    assign tx_count = tx_wr - tx_rd;
    assign rx_count = rx_wr - rx_rd;
    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == DEPTH);
    assign rx_full  = (rx_count == DEPTH);

    assign wr_ctrl     = bus_write && (addr_word == A_CTRL);
    assign wr_irq_en   = bus_write && (addr_word == A_IRQ_EN);
    assign w1c         = (bus_write && (addr_word == A_IRQ_STATUS)) ? wdata[3:0] : 4'h0;
    assign tx_push_req = bus_write && (addr_word == A_TXDATA);
    assign rx_pop      = bus_read && (addr_word == A_RXDATA) && !rx_empty;

    assign tx_pop      = load && !tx_empty;
    assign underrun    = load && tx_empty;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop     = tx_push_req && !tx_push;
    assign rx_push_req = sample_edge && (bit_cnt == 3'd7);
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign overrun     = rx_push_req && !rx_push;

    assign tx_count_next = tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    assign rx_count_next = rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);

    assign irq_set = {stop, underrun || overrun || tx_drop,
                      tx_pop && (tx_count_next == '0), rx_push};
    assign irq_clr = w1c | {2'b00, tx_push_req, rx_pop && (rx_count_next == '0)};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_byte_new;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {sck_s1, sck_s2, sck_d} <= 3'b000;
            {cs_s1, cs_s2, cs_d}    <= 3'b111;
            {mosi_s1, mosi_s2}      <= 2'b00;
            sync_age                <= 2'd0;
            {lsb_first, cpha, cpol, enable} <= 4'h1;
            irq_en     <= 4'h0;
            irq_status <= 4'h0;
            fault      <= 1'b0;
            tx_wr      <= '0;
            tx_rd      <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            bit_cnt    <= 3'd0;
            tx_shift   <= 8'h00;
            rx_shift   <= 8'h00;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            if (!sync_ok) sync_age <= sync_age + 2'd1;

            if (wr_ctrl)   {lsb_first, cpha, cpol, enable} <= wdata[3:0];
            if (wr_irq_en) irq_en <= wdata[3:0];

            // Hardware sets are OR-ed in last so they win over a same-cycle clear.
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            if (underrun || overrun || tx_drop) fault <= 1'b1;
            else if (w1c[2])                    fault <= 1'b0;

            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;

            if (load)            tx_shift <= tx_empty ? FILL_BYTE : tx_mem[tx_rd[AW-1:0]];
            else if (shift_edge) tx_shift <= lsb_first ? (tx_shift >> 1) : (tx_shift << 1);

            if (start) bit_cnt <= 3'd0;
            if (sample_edge) begin
                rx_shift <= rx_byte_new;
                bit_cnt  <= bit_cnt + 3'd1;
            end
        end
    end

    assign spi_miso_oe = (state_q == ACTIVE);
    assign spi_miso    = (state_q == ACTIVE) && (lsb_first ? tx_shift[0] : tx_shift[7]);
    assign irq         = |(irq_en & irq_status);

    always_comb begin
        rdata = 32'h0;
        if (bus_read) begin
            case (addr_word)
                A_CTRL:       rdata = {28'h0, lsb_first, cpha, cpol, enable};
                A_STATUS:     rdata = {28'h0, fault, state_q == ACTIVE, !rx_empty, !tx_full};
                A_TXDATA:     rdata = {{(31-AW){1'b0}}, tx_count};
                A_RXDATA:     rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd[AW-1:0]]};
                A_IRQ_EN:     rdata = {28'h0, irq_en};
                A_IRQ_STATUS: rdata = {28'h0, irq_status};
                default:      rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_qar_spi_target.sv
// Self-checking bench for qar_spi_target: a behavioural SPI controller drives
// frames in all four modes plus underrun, overrun, aborted-frame and reset corners.
module tb_qar_spi_target;
    localparam int H = 8;  // SCK half-period and CS setup/hold, in clk cycles

    localparam logic [5:0] A_CTRL       = 6'd0;
    localparam logic [5:0] A_STATUS     = 6'd1;
    localparam logic [5:0] A_TXDATA     = 6'd3;
    localparam logic [5:0] A_RXDATA     = 6'd4;
    localparam logic [5:0] A_IRQ_EN     = 6'd6;
    localparam logic [5:0] A_IRQ_STATUS = 6'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [5:0]  addr_word = 6'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_miso;
    logic        spi_miso_oe;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;

    typedef struct {
        bit         cpol;
        bit         cpha;
        bit         lsb;
        logic [7:0] tx_byte;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[5];

    qar_spi_target #(.FIFO_DEPTH(4), .FILL_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .bus_write(bus_write), .bus_read(bus_read),
        .addr_word(addr_word), .wdata(wdata), .rdata(rdata), .irq(irq),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_word = a;
        wdata     = d;
        bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_word = a;
        bus_read  = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        bus_read = 1'b0;
    endtask

    task automatic set_mode(input bit cpol, input bit cpha, input bit lsb);
        m_cpol  = cpol;
        m_cpha  = cpha;
        m_lsb   = lsb;
        spi_sck = cpol;
        wait_clk(4);
        bus_wr(A_CTRL, {28'h0, lsb, cpha, cpol, 1'b1});
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_high();
        wait_clk(H);
        spi_cs_n = 1'b1;
        wait_clk(H);
    endtask

    // Controller side: shifts nbits of mo out on MOSI and assembles MISO into mi.
    // hold_last leaves SCK on the leading level after the final bit (cpha=0 only).
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit hold_last,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = m_lsb ? i : 7 - i;
            if (!m_cpha) begin
                spi_mosi = mo[b];
                wait_clk(H);
                spi_sck = ~m_cpol;
                mi[b]   = spi_miso;
                wait_clk(H);
                if (!(hold_last && i == nbits - 1)) spi_sck = m_cpol;
            end else begin
                spi_sck  = ~m_cpol;
                spi_mosi = mo[b];
                wait_clk(H);
                spi_sck = m_cpol;
                mi[b]   = spi_miso;
                wait_clk(H);
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  mi, mi2;
        logic [7:0]  rx_bytes[5];

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h96, 8'h0F, 8'h96, 8'h0F};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'hE4, 8'h27, 8'hE4, 8'h27};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h3C, 8'hA1, 8'h3C, 8'hA1};
        rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset state
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        check("rst_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("rst_miso", {31'h0, spi_miso}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rdata_idle", rdata, 32'h0);
        bus_rd(A_CTRL, d);       check("rst_ctrl", d, 32'h1);
        bus_rd(A_STATUS, d);     check("rst_status", d, 32'h1);
        bus_rd(A_IRQ_STATUS, d); check("rst_irq_status", d, 32'h0);
        bus_rd(A_TXDATA, d);     check("rst_tx_count", d, 32'h0);
        bus_rd(A_RXDATA, d);     check("rst_rx_empty_read", d, 32'h0);

        // Mode 0, MSB first: 0xA5 out, 0x3C in
        bus_wr(A_TXDATA, 32'hA5);
        cs_low();
        spi_bits(8'h3C, 8, 1'b1, mi);
        bus_rd(A_IRQ_STATUS, d); check("m0_irq_after_byte", d, 32'h3);
        spi_sck = 1'b0;
        cs_high();
        check("m0_miso", {24'h0, mi}, 32'hA5);
        bus_rd(A_IRQ_STATUS, d); check("m0_irq_frame_end", d & 32'hB, 32'hB);
        bus_wr(A_IRQ_EN, 32'h8);
        check("irq_pin_set", {31'h0, irq}, 32'h1);
        bus_wr(A_IRQ_STATUS, 32'h8);
        check("irq_pin_clr", {31'h0, irq}, 32'h0);
        bus_wr(A_IRQ_EN, 32'h0);
        bus_rd(A_RXDATA, d);     check("m0_rx", d, 32'h3C);
        bus_rd(A_IRQ_STATUS, d); check("m0_rx_irq_clr_on_empty", {31'h0, d[0]}, 32'h0);

        // Single-byte frames across modes and bit orders
        for (int v = 0; v < 5; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb);
            bus_wr(A_IRQ_STATUS, 32'hF);
            bus_wr(A_TXDATA, {24'h0, vecs[v].tx_byte});
            cs_low();
            spi_bits(vecs[v].mosi_byte, 8, 1'b0, mi);
            cs_high();
            check($sformatf("vec%0d_miso", v), {24'h0, mi}, {24'h0, vecs[v].exp_miso});
            bus_rd(A_RXDATA, d);
            check($sformatf("vec%0d_rx", v), d, {24'h0, vecs[v].exp_rx});
        end

        // Mode 3, LSB first, two-byte frame
        set_mode(1'b1, 1'b1, 1'b1);
        bus_wr(A_IRQ_STATUS, 32'hF);
        bus_wr(A_TXDATA, 32'h81);
        bus_wr(A_TXDATA, 32'h0F);
        cs_low();
        spi_bits(8'h12, 8, 1'b0, mi);
        spi_bits(8'h34, 8, 1'b0, mi2);
        cs_high();
        check("m3_miso0", {24'h0, mi}, 32'h81);
        check("m3_miso1", {24'h0, mi2}, 32'h0F);
        bus_rd(A_RXDATA, d); check("m3_rx0", d, 32'h12);
        bus_rd(A_RXDATA, d); check("m3_rx1", d, 32'h34);

        // TX underrun: fill byte, fault, cleared by W1C of bit 2
        set_mode(1'b1, 1'b1, 1'b0);
        bus_wr(A_IRQ_STATUS, 32'hF);
        bus_rd(A_STATUS, d); check("ur_fault_before", {31'h0, d[3]}, 32'h0);
        cs_low();
        spi_bits(8'h00, 8, 1'b0, mi);
        cs_high();
        check("ur_miso_fill", {24'h0, mi}, 32'hFF);
        bus_rd(A_STATUS, d);     check("ur_fault_set", {31'h0, d[3]}, 32'h1);
        bus_rd(A_IRQ_STATUS, d); check("ur_irq2_set", {31'h0, d[2]}, 32'h1);
        bus_wr(A_IRQ_STATUS, 32'h4);
        bus_rd(A_STATUS, d);     check("ur_fault_clr", {31'h0, d[3]}, 32'h0);
        bus_rd(A_IRQ_STATUS, d); check("ur_irq2_clr", {31'h0, d[2]}, 32'h0);
        bus_rd(A_RXDATA, d);     check("ur_rx", d, 32'h00);

        // RX overrun: four bytes kept, fifth dropped
        bus_wr(A_IRQ_STATUS, 32'hF);
        for (int k = 0; k < 4; k++) bus_wr(A_TXDATA, 32'hA1 + k);
        bus_rd(A_TXDATA, d); check("ov_tx_count_full", d, 32'h4);
        bus_rd(A_STATUS, d); check("ov_tx_not_ready", {31'h0, d[0]}, 32'h0);
        cs_low();
        for (int k = 0; k < 4; k++) begin
            spi_bits(rx_bytes[k], 8, 1'b0, mi);
            check($sformatf("ov_miso%0d", k), {24'h0, mi}, 32'hA1 + k);
        end
        bus_wr(A_IRQ_STATUS, 32'hF);
        bus_rd(A_STATUS, d); check("ov_status_mid", d, 32'h7);
        bus_wr(A_TXDATA, 32'hA5);
        spi_bits(rx_bytes[4], 8, 1'b0, mi);
        cs_high();
        check("ov_miso4", {24'h0, mi}, 32'hA5);
        bus_rd(A_STATUS, d);     check("ov_fault", {31'h0, d[3]}, 32'h1);
        bus_rd(A_IRQ_STATUS, d); check("ov_irq2", {31'h0, d[2]}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            bus_rd(A_RXDATA, d);
            check($sformatf("ov_rx%0d", k), d, {24'h0, rx_bytes[k]});
        end
        bus_rd(A_RXDATA, d); check("ov_rx_empty", d, 32'h0);

        // Frame aborted after 3 bits, then a clean 1-byte frame
        bus_wr(A_IRQ_STATUS, 32'hF);
        cs_low();
        spi_bits(8'hFF, 3, 1'b0, mi);
        cs_high();
        bus_rd(A_IRQ_STATUS, d); check("ab_frame_end1", {31'h0, d[3]}, 32'h1);
        bus_rd(A_STATUS, d);     check("ab_no_rx", {31'h0, d[1]}, 32'h0);
        bus_wr(A_IRQ_STATUS, 32'h8);
        bus_rd(A_IRQ_STATUS, d); check("ab_frame_end_clr", {31'h0, d[3]}, 32'h0);
        bus_wr(A_TXDATA, 32'hC3);
        cs_low();
        spi_bits(8'h55, 8, 1'b0, mi);
        cs_high();
        check("ab_miso", {24'h0, mi}, 32'hC3);
        bus_rd(A_RXDATA, d);     check("ab_rx", d, 32'h55);
        bus_rd(A_RXDATA, d);     check("ab_rx_only_one", d, 32'h0);
        bus_rd(A_IRQ_STATUS, d); check("ab_frame_end2", {31'h0, d[3]}, 32'h1);

        // One-cycle reset in the middle of a frame with CS held low
        set_mode(1'b0, 1'b0, 1'b0);
        bus_wr(A_IRQ_STATUS, 32'hF);
        bus_wr(A_TXDATA, 32'h99);
        cs_low();
        spi_bits(8'hFF, 3, 1'b0, mi);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("mr_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("mr_miso", {31'h0, spi_miso}, 32'h0);
        bus_rd(A_TXDATA, d); check("mr_tx_empty", d, 32'h0);
        bus_rd(A_STATUS, d); check("mr_status", d, 32'h1);
        spi_bits(8'hFF, 5, 1'b0, mi);
        spi_bits(8'hAA, 8, 1'b0, mi);
        bus_rd(A_STATUS, d); check("mr_no_rx_cs_low", d, 32'h1);
        check("mr_miso_oe_idle", {31'h0, spi_miso_oe}, 32'h0);
        cs_high();
        bus_wr(A_TXDATA, 32'h6A);
        cs_low();
        spi_bits(8'hE7, 8, 1'b0, mi);
        cs_high();
        check("mr_miso_after", {24'h0, mi}, 32'h6A);
        bus_rd(A_RXDATA, d); check("mr_rx_after", d, 32'hE7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
